// File: rtl/wash_pkg.sv
// wash_pkg: shared definitions for the washing machine program controller.
//   state_e   - top-level controller states (encoding is the `state` port value)
//   stage_e   - program stage codes (encoding is msg[15:13])
//   MOTOR_*   - motor drive codes
//   MSG_*     - bit offsets/widths of the fields inside the 26-bit msg word
//   program table helpers: which modes include a wash, how many rinses,
//   per-stage durations and whole-program tick totals.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    STG_NONE  = 3'd0,
    STG_FILL  = 3'd1,
    STG_WASH  = 3'd2,
    STG_DRAIN = 3'd3,
    STG_RINSE = 3'd4,
    STG_SPIN  = 3'd5
  } stage_e;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_AGIT = 2'b01;
  localparam logic [1:0] MOTOR_SPIN = 2'b10;

  localparam int MSG_W          = 26;
  localparam int MSG_MODE_LSB   = 23;
  localparam int MSG_MODE_W     = 3;
  localparam int MSG_STICK_LSB  = 19;
  localparam int MSG_STICK_W    = 4;
  localparam int MSG_RINSE_LSB  = 16;
  localparam int MSG_RINSE_W    = 3;
  localparam int MSG_STAGE_LSB  = 13;
  localparam int MSG_STAGE_W    = 3;
  localparam int MSG_TOTAL_LSB  = 5;
  localparam int MSG_TOTAL_W    = 8;
  localparam int MSG_DONECT_LSB = 2;
  localparam int MSG_DONECT_W   = 3;
  localparam int MSG_PAUSED_BIT = 1;
  localparam int MSG_DONE_BIT   = 0;

  function automatic logic prog_has_wash(input logic [1:0] mode);
    return (mode == 2'd0) || (mode == 2'd1);
  endfunction

  function automatic logic [2:0] prog_rinses(input logic [1:0] mode);
    case (mode)
      2'd0:    return 3'd2;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] stage_ticks(input stage_e s, input int fill_t,
                                             input int wash_t, input int drain_t,
                                             input int rinse_t, input int spin_t);
    case (s)
      STG_FILL:  return 4'(fill_t);
      STG_WASH:  return 4'(wash_t);
      STG_DRAIN: return 4'(drain_t);
      STG_RINSE: return 4'(rinse_t);
      STG_SPIN:  return 4'(spin_t);
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] prog_total(input logic [1:0] mode, input int fill_t,
                                            input int wash_t, input int drain_t,
                                            input int rinse_t, input int spin_t);
    int t;
    t = spin_t;
    if (prog_has_wash(mode)) t = t + fill_t + wash_t + drain_t;
    t = t + int'(prog_rinses(mode)) * (fill_t + rinse_t + drain_t);
    return 8'(t);
  endfunction

endpackage

// File: rtl/wash_stage_next.sv
// wash_stage_next: combinational successor of the running stage.
//   stage_i/phase_i/rinses_i - current stage, phase (0 wash, 1 rinse), rinses left
//   stage_o/phase_o/rinses_o - stage to enter when the current one expires
//   load_o                   - duration of stage_o in ticks
//   last_o                   - current stage was SPIN; the program is finished
module wash_stage_next
  import wash_pkg::*;
#(
  parameter int FILL_T  = 3,
  parameter int WASH_T  = 9,
  parameter int DRAIN_T = 3,
  parameter int RINSE_T = 6,
  parameter int SPIN_T  = 6
) (
  input  stage_e     stage_i,
  input  logic       phase_i,
  input  logic [2:0] rinses_i,
  output stage_e     stage_o,
  output logic       phase_o,
  output logic [2:0] rinses_o,
  output logic [3:0] load_o,
  output logic       last_o
);

  always_comb begin
    stage_o  = STG_NONE;
    phase_o  = phase_i;
    rinses_o = rinses_i;
    last_o   = 1'b0;
    case (stage_i)
      STG_FILL:  stage_o = phase_i ? STG_RINSE : STG_WASH;
      STG_WASH:  stage_o = STG_DRAIN;
      STG_RINSE: stage_o = STG_DRAIN;
      STG_DRAIN: begin
        // A rinse DRAIN consumes one rinse; a wash DRAIN only hands over.
        if (phase_i) begin
          rinses_o = rinses_i - 3'd1;
          if (rinses_i > 3'd1) stage_o = STG_FILL;
          else                 stage_o = STG_SPIN;
        end else begin
          phase_o = 1'b1;
          if (rinses_i != 3'd0) stage_o = STG_FILL;
          else                  stage_o = STG_SPIN;
        end
      end
      STG_SPIN:  last_o = 1'b1;
      default:   stage_o = STG_NONE;
    endcase
    load_o = stage_ticks(stage_o, FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T);
  end

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: washing machine main program controller.
//   cp, rst           - clock, async active-high reset
//   tick              - one-cycle time-base enable
//   power/start_pause/mode_next - one-cycle user pulses
//   state             - controller state code for the display
//   msg               - status word for the display
//   valve_in/valve_out/motor/buzzer - registered actuator drives
//
// state | meaning
// OFF   | machine off, everything cleared
// SET   | program selection, total shown for selected mode
// RUN   | stages counting down on tick
// PAUSE | timers frozen, actuators off
// DONE  | program finished, buzzer sounds for BUZZ_T ticks
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int FILL_T  = 3,
  parameter int WASH_T  = 9,
  parameter int DRAIN_T = 3,
  parameter int RINSE_T = 6,
  parameter int SPIN_T  = 6,
  parameter int BUZZ_T  = 5
) (
  input  logic                 cp,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 power,
  input  logic                 start_pause,
  input  logic                 mode_next,
  output logic [2:0]           state,
  output logic [MSG_W-1:0]     msg,
  output logic                 valve_in,
  output logic                 valve_out,
  output logic [1:0]           motor,
  output logic                 buzzer
);

  state_e     state_q, state_d;
  stage_e     stage_q, stage_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] sticks_q, sticks_d;
  logic [2:0] rinses_q, rinses_d;
  logic [7:0] total_q, total_d;
  logic [2:0] donect_q, donect_d;
  logic       phase_q, phase_d;
  logic [7:0] buzz_q, buzz_d;
  logic       paused_q, paused_d;
  logic       done_q, done_d;
  logic       valve_in_q, valve_in_d;
  logic       valve_out_q, valve_out_d;
  logic [1:0] motor_q, motor_d;
  logic       buzzer_q, buzzer_d;

  stage_e     nx_stage;
  logic       nx_phase;
  logic [2:0] nx_rinses;
  logic [3:0] nx_load;
  logic       nx_last;

  wash_stage_next #(
    .FILL_T(FILL_T), .WASH_T(WASH_T), .DRAIN_T(DRAIN_T),
    .RINSE_T(RINSE_T), .SPIN_T(SPIN_T)
  ) u_next (
    .stage_i (stage_q),
    .phase_i (phase_q),
    .rinses_i(rinses_q),
    .stage_o (nx_stage),
    .phase_o (nx_phase),
    .rinses_o(nx_rinses),
    .load_o  (nx_load),
    .last_o  (nx_last)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    mode_d   = mode_q;
    sticks_d = sticks_q;
    rinses_d = rinses_q;
    total_d  = total_q;
    donect_d = donect_q;
    phase_d  = phase_q;
    buzz_d   = buzz_q;
    paused_d = paused_q;
    done_d   = done_q;

    if (power && state_q != ST_OFF) begin
      state_d  = ST_OFF;
      stage_d  = STG_NONE;
      mode_d   = 2'd0;
      sticks_d = 4'd0;
      rinses_d = 3'd0;
      total_d  = 8'd0;
      donect_d = 3'd0;
      phase_d  = 1'b0;
      buzz_d   = 8'd0;
      paused_d = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (power) begin
            state_d = ST_SET;
            mode_d  = 2'd0;
            total_d = prog_total(2'd0, FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T);
          end
        end
        ST_SET: begin
          if (start_pause) begin
            state_d  = ST_RUN;
            rinses_d = prog_rinses(mode_q);
            donect_d = 3'd0;
            if (prog_has_wash(mode_q)) begin
              stage_d = STG_FILL;
              phase_d = 1'b0;
            end else if (prog_rinses(mode_q) != 3'd0) begin
              stage_d = STG_FILL;
              phase_d = 1'b1;
            end else begin
              stage_d = STG_SPIN;
              phase_d = 1'b1;
            end
            sticks_d = stage_ticks(stage_d, FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T);
          end else if (mode_next) begin
            mode_d  = mode_q + 2'd1;
            total_d = prog_total(mode_d, FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T);
          end
        end
        ST_RUN: begin
          if (start_pause) begin
            state_d  = ST_PAUSE;
            paused_d = 1'b1;
          end else if (tick) begin
            total_d = total_q - 8'd1;
            if (sticks_q == 4'd1) begin
              donect_d = (donect_q == 3'd7) ? donect_q : donect_q + 3'd1;
              if (nx_last) begin
                state_d  = ST_DONE;
                stage_d  = STG_NONE;
                sticks_d = 4'd0;
                total_d  = 8'd0;
                done_d   = 1'b1;
                buzz_d   = 8'(BUZZ_T);
              end else begin
                stage_d  = nx_stage;
                phase_d  = nx_phase;
                rinses_d = nx_rinses;
                sticks_d = nx_load;
              end
            end else begin
              sticks_d = sticks_q - 4'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (start_pause) begin
            state_d  = ST_RUN;
            paused_d = 1'b0;
          end
        end
        ST_DONE: begin
          if (start_pause) begin
            state_d  = ST_SET;
            done_d   = 1'b0;
            buzz_d   = 8'd0;
            donect_d = 3'd0;
            rinses_d = 3'd0;
            phase_d  = 1'b0;
            total_d  = prog_total(mode_q, FILL_T, WASH_T, DRAIN_T, RINSE_T, SPIN_T);
          end else if (tick && buzz_q != 8'd0) begin
            buzz_d = buzz_q - 8'd1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Actuators are decoded from the next state so they land with it.
    valve_in_d  = 1'b0;
    valve_out_d = 1'b0;
    motor_d     = MOTOR_STOP;
    if (state_d == ST_RUN) begin
      case (stage_d)
        STG_FILL:  valve_in_d = 1'b1;
        STG_WASH:  motor_d = MOTOR_AGIT;
        STG_RINSE: motor_d = MOTOR_AGIT;
        STG_DRAIN: valve_out_d = 1'b1;
        STG_SPIN: begin
          motor_d     = MOTOR_SPIN;
          valve_out_d = 1'b1;
        end
        default: motor_d = MOTOR_STOP;
      endcase
    end
    buzzer_d = (state_d == ST_DONE) && (buzz_d != 8'd0);
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      stage_q     <= STG_NONE;
      mode_q      <= 2'd0;
      sticks_q    <= 4'd0;
      rinses_q    <= 3'd0;
      total_q     <= 8'd0;
      donect_q    <= 3'd0;
      phase_q     <= 1'b0;
      buzz_q      <= 8'd0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
      valve_in_q  <= 1'b0;
      valve_out_q <= 1'b0;
      motor_q     <= MOTOR_STOP;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      mode_q      <= mode_d;
      sticks_q    <= sticks_d;
      rinses_q    <= rinses_d;
      total_q     <= total_d;
      donect_q    <= donect_d;
      phase_q     <= phase_d;
      buzz_q      <= buzz_d;
      paused_q    <= paused_d;
      done_q      <= done_d;
      valve_in_q  <= valve_in_d;
      valve_out_q <= valve_out_d;
      motor_q     <= motor_d;
      buzzer_q    <= buzzer_d;
    end
  end

  // msg is pure wiring of registered fields.
  always_comb begin
    msg = '0;
    msg[MSG_MODE_LSB   +: MSG_MODE_W]   = {1'b0, mode_q};
    msg[MSG_STICK_LSB  +: MSG_STICK_W]  = sticks_q;
    msg[MSG_RINSE_LSB  +: MSG_RINSE_W]  = rinses_q;
    msg[MSG_STAGE_LSB  +: MSG_STAGE_W]  = stage_q;
    msg[MSG_TOTAL_LSB  +: MSG_TOTAL_W]  = total_q;
    msg[MSG_DONECT_LSB +: MSG_DONECT_W] = donect_q;
    msg[MSG_PAUSED_BIT]                 = paused_q;
    msg[MSG_DONE_BIT]                   = done_q;
  end

  assign state     = state_q;
  assign valve_in  = valve_in_q;
  assign valve_out = valve_out_q;
  assign motor     = motor_q;
  assign buzzer    = buzzer_q;

endmodule
